// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD arithmetic datapath: digit geometry,
// sequencer states and a digit range check.
package bcd_pkg;

   localparam int BCD_W     = 4;
   localparam int BCD_RADIX = 10;

   typedef enum logic [1:0] {
      IDLE,
      SUB,
      FIX,
      DONE
   } state_t;

   function automatic logic bcd_digit_valid(input logic [BCD_W-1:0] digit);
      return digit <= BCD_W'(9);
   endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// Single-digit BCD subtract with borrow: d = x - y - bin, wrapped into 0..9
// by adding the radix when the raw difference goes negative.
module bcd_digit_sub
   import bcd_pkg::*;
(
   input  logic [BCD_W-1:0] x,
   input  logic [BCD_W-1:0] y,
   input  logic             bin,
   output logic [BCD_W-1:0] d,
   output logic             bout
);

   logic [BCD_W:0] t;

   always_comb begin
      t    = {1'b0, x} - {1'b0, y} - {{BCD_W{1'b0}}, bin};
      bout = t[BCD_W];
      d    = bout ? BCD_W'(t + (BCD_W+1)'(BCD_RADIX)) : t[BCD_W-1:0];
   end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor returning |a-b| and a sign flag; a negative raw
// result is turned into its magnitude by a second ten's-complement pass.
module bcd_serial_subtractor
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [BCD_W*DIGITS-1:0]   a,
   input  logic [BCD_W*DIGITS-1:0]   b,
   output logic                      busy,
   output logic                      done,
   output logic [BCD_W*DIGITS-1:0]   diff,
   output logic                      negative,
   output logic                      invalid
);

   localparam int W  = BCD_W * DIGITS;
   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    r_q, r_d;
   logic            borrow_q, borrow_d;
   logic            negative_q, negative_d;
   logic            invalid_q, invalid_d;

   logic [DIGITS-1:0] digit_ok;
   logic [BCD_W-1:0]  dig_x, dig_y, dig_d;
   logic              dig_bout;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_valid
      assign digit_ok[gi] = bcd_digit_valid(a[gi*BCD_W +: BCD_W]) &&
                            bcd_digit_valid(b[gi*BCD_W +: BCD_W]);
   end

   bcd_digit_sub u_digit (
      .x    (dig_x),
      .y    (dig_y),
      .bin  (borrow_q),
      .d    (dig_d),
      .bout (dig_bout)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      r_d        = r_q;
      borrow_d   = borrow_q;
      negative_d = negative_q;
      invalid_d  = invalid_q;
      dig_x      = a_q[BCD_W-1:0];
      dig_y      = b_q[BCD_W-1:0];

      // The correction pass computes 0 - R, reusing the same digit stage.
      if (state_q == FIX) begin
         dig_x = '0;
         dig_y = r_q[BCD_W-1:0];
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d        = a;
               b_d        = b;
               borrow_d   = 1'b0;
               cnt_d      = '0;
               negative_d = 1'b0;
               invalid_d  = ~&digit_ok;
               state_d    = SUB;
            end
         end
         SUB: begin
            a_d      = a_q >> BCD_W;
            b_d      = b_q >> BCD_W;
            r_d      = W'({dig_d, r_q} >> BCD_W);
            borrow_d = dig_bout;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d = '0;
               if (dig_bout) begin
                  borrow_d   = 1'b0;
                  negative_d = 1'b1;
                  state_d    = FIX;
               end else begin
                  state_d = DONE;
               end
            end
         end
         FIX: begin
            r_d      = W'({dig_d, r_q} >> BCD_W);
            borrow_d = dig_bout;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         r_q        <= '0;
         borrow_q   <= 1'b0;
         negative_q <= 1'b0;
         invalid_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         r_q        <= r_d;
         borrow_q   <= borrow_d;
         negative_q <= negative_d;
         invalid_q  <= invalid_d;
      end
   end

   assign busy     = (state_q != IDLE);
   assign done     = (state_q == DONE);
   assign diff     = r_q;
   assign negative = negative_q;
   assign invalid  = invalid_q;

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Randomised and directed bench for bcd_serial_subtractor against an
// integer-arithmetic model of |a-b|, sign, validity and completion time.
module tb_bcd_serial_subtractor;

   localparam int D = 4;
   localparam int W = 4 * D;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, negative, invalid;
   logic [W-1:0] diff;

   int n_checks = 0;
   int n_errors = 0;

   bcd_serial_subtractor #(.DIGITS(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .diff     (diff),
      .negative (negative),
      .invalid  (invalid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   function automatic int bcd_val(input logic [W-1:0] v);
      int s = 0;
      for (int i = D - 1; i >= 0; i--) s = s * 10 + int'(v[i*4 +: 4]);
      return s;
   endfunction

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r = '0;
      int x = v;
      for (int i = 0; i < D; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic bit all_valid(input logic [W-1:0] v);
      for (int i = 0; i < D; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   // Whether the first pass ends with a borrow; for illegal digits apply the
   // per-digit rule directly since the decimal value is not meaningful.
   function automatic bit first_pass_borrow(input logic [W-1:0] av, input logic [W-1:0] bv);
      int bin = 0;
      int t;
      if (all_valid(av) && all_valid(bv)) return bcd_val(av) < bcd_val(bv);
      for (int i = 0; i < D; i++) begin
         t   = int'(av[i*4 +: 4]) - int'(bv[i*4 +: 4]) - bin;
         bin = (t < 0) ? 1 : 0;
      end
      return bin != 0;
   endfunction

   // Behavioural model plus per-cycle compare
   int           edge_n = 0;
   bit           m_active = 1'b0;
   int           m_done_edge = 0;
   bit           m_hold = 1'b1;
   logic [W-1:0] m_diff = '0;
   bit           m_neg = 1'b0;
   bit           m_inv = 1'b0;

   always @(posedge clk) begin
      bit exp_busy, exp_done;
      int ia, ib;
      edge_n++;
      if (rst) begin
         m_active = 1'b0;
         m_hold   = 1'b1;
         m_diff   = '0;
         m_neg    = 1'b0;
         m_inv    = 1'b0;
      end else if ((!m_active || edge_n >= m_done_edge + 2) && start) begin
         ia          = bcd_val(a);
         ib          = bcd_val(b);
         m_active    = 1'b1;
         m_done_edge = edge_n + (first_pass_borrow(a, b) ? 2 * D : D);
         m_inv       = !(all_valid(a) && all_valid(b));
         m_neg       = ia < ib;
         m_diff      = to_bcd(ia < ib ? ib - ia : ia - ib);
         m_hold      = 1'b0;
      end
      #1;
      exp_busy = m_active && edge_n <= m_done_edge;
      exp_done = m_active && edge_n == m_done_edge;
      check("busy", busy, exp_busy);
      check("done", done, exp_done);
      if (exp_done) m_hold = 1'b1;
      if (m_hold) begin
         check("invalid", invalid, m_inv);
         if (!m_inv) begin
            check("diff", diff, m_diff);
            check("negative", negative, m_neg);
         end
      end
   end

   int acc;

   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
      @(posedge clk); #2;
      a = av;
      b = bv;
      start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      acc = edge_n;
   endtask

   task automatic wait_done(output int cyc);
      cyc = -1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #2;
         if (done) begin
            cyc = edge_n - acc + 1;
            break;
         end
      end
      if (cyc < 0) check("done_timeout", 0, 1);
   endtask

   task automatic directed(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [W-1:0] ediff, input bit eneg, input bit einv,
                           input int ecyc);
      int cyc;
      issue(av, bv);
      wait_done(cyc);
      check("done_cycle", cyc, ecyc);
      check("lit_invalid", invalid, einv);
      if (!einv) begin
         check("lit_diff", diff, ediff);
         check("lit_negative", negative, eneg);
      end
      $display("op a=%h b=%h -> diff=%h neg=%0b inv=%0b cycle=%0d", av, bv, diff, negative, invalid, cyc);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1);
   end

   initial begin
      int cyc, cnt, edges[$];
      logic [W-1:0] ra, rb, seen;

      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      check("reset_busy", busy, 0);
      check("reset_diff", diff, 0);

      directed(16'h4321, 16'h1234, 16'h3087, 0, 0, 5);
      directed(16'h1234, 16'h4321, 16'h3087, 1, 0, 9);
      directed(16'h0000, 16'h0001, 16'h0001, 1, 0, 9);
      directed(16'h9999, 16'h9999, 16'h0000, 0, 0, 5);
      directed(16'h1000, 16'h0001, 16'h0999, 0, 0, 5);
      directed(16'h00A0, 16'h0001, 16'h0000, 0, 1, 5);
      directed(16'h0050, 16'h0020, 16'h0030, 0, 0, 5);

      // Second start mid-operation must be ignored
      issue(16'h4321, 16'h1234);
      @(posedge clk); #2;
      a = 16'h1111; b = 16'h2222; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      cnt = 0; seen = '0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #2;
         if (done) begin
            cnt++;
            seen = diff;
            check("ignored_start_cycle", edge_n - acc + 1, 5);
         end
      end
      check("ignored_start_dones", cnt, 1);
      check("ignored_start_diff", seen, 16'h3087);
      $display("op ignored-start dones=%0d diff=%h", cnt, seen);

      // Start held high: back-to-back operations
      @(posedge clk); #2;
      a = 16'h0500; b = 16'h0123; start = 1'b1;
      @(posedge clk); #2;
      acc = edge_n;
      for (int i = 0; i < 17; i++) begin
         @(posedge clk); #2;
         if (done) edges.push_back(edge_n - acc + 1);
      end
      start = 1'b0;
      check("held_count", edges.size(), 3);
      if (edges.size() == 3) begin
         check("held_done0", edges[0], 5);
         check("held_done1", edges[1], 11);
         check("held_done2", edges[2], 17);
      end
      $display("op held-start dones=%0d", edges.size());
      repeat (3) @(posedge clk);

      // Reset in the middle of a negative operation
      issue(16'h1234, 16'h4321);
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_diff", diff, 0);
      check("abort_negative", negative, 0);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #2;
         if (done) cnt++;
      end
      check("abort_no_done", cnt, 0);
      $display("op reset-abort dones_after=%0d", cnt);
      directed(16'h0777, 16'h0778, 16'h0001, 1, 0, 9);

      // Random operations, occasionally with an illegal digit
      for (int n = 0; n < 40; n++) begin
         int ecyc;
         for (int i = 0; i < D; i++) begin
            ra[i*4 +: 4] = 4'($urandom_range(0, 9));
            rb[i*4 +: 4] = 4'($urandom_range(0, 9));
         end
         if ($urandom_range(0, 7) == 0) ra[$urandom_range(0, D-1)*4 +: 4] = 4'($urandom_range(10, 15));
         ecyc = first_pass_borrow(ra, rb) ? 2 * D + 1 : D + 1;
         issue(ra, rb);
         wait_done(cyc);
         check("rand_cycle", cyc, ecyc);
         $display("op a=%h b=%h -> diff=%h neg=%0b inv=%0b cycle=%0d", ra, rb, diff, negative, invalid, cyc);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end

      repeat (3) @(posedge clk);
      #3;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
